corner_packer: RTL and testbench



---
 rtl/corner_packer.sv | 173 +++++++++++++++++
 tb/tb_corner_packer.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/corner_packer.sv
// Packs 32-bit corner words into 128-bit entries and queues them in a show-ahead FIFO.
// At each frame end it pads out any partial entry and appends a frame trailer.
module corner_packer #(
  parameter int DEPTH       = 16,
  parameter int FLUSH_DELAY = 32
) (
  input  logic         c,
  input  logic         rst_n,
  input  logic [31:0]  d,
  input  logic         dv,
  input  logic         fv,
  output logic [127:0] q,
  output logic         qv,
  input  logic         qr,
  output logic         overflow,
  output logic [15:0]  frame_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int DW = $clog2(FLUSH_DELAY + 2);
  localparam logic [31:0] PAD     = 32'hFFFF_FFFF;
  localparam logic [31:0] TRL_TAG = 32'hFFFF_E0F0;

  typedef enum logic [1:0] {COLLECT, WAIT, FLUSH, TRAILER} state_e;

  state_e          state_q;
  logic [DW-1:0]   dly_q;
  logic [2:0][31:0] lane_q;
  logic [1:0]      li_q;
  logic            wr_pend_q;
  logic [127:0]    wr_data_q;
  logic [127:0]    mem_q [DEPTH];
  logic [PW-1:0]   wp_q, rp_q;
  logic [PW:0]     cnt_q;
  logic            fv_d1_q;
  logic            ovf_q;
  logic [15:0]     corner_q, drop_q, corner_d, drop_d;
  logic [15:0]     snap_corner_q, snap_drop_q;
  logic [15:0]     frame_q;

  logic            full, collecting, take, lost, entry_drop, fsm_wr, wr_en, pop, snap_now;
  logic [127:0]    wr_data, pad_entry, trl_entry;
  logic [16:0]     corner_sum, drop_sum;
  logic [2:0]      drop_inc;

  assign full       = (cnt_q == (PW+1)'(DEPTH));
  assign collecting = (state_q == COLLECT) || (state_q == WAIT);
  assign take       = dv & collecting;
  assign lost       = dv & ~collecting;
  assign entry_drop = wr_pend_q & full;
  // Pad/trailer writes yield to a pending collector entry so the two never collide.
  assign fsm_wr     = ~wr_pend_q & ~full &
                      (((state_q == FLUSH) && (li_q != 2'd0)) || (state_q == TRAILER));
  assign wr_en      = (wr_pend_q & ~full) | fsm_wr;
  assign qv         = (cnt_q != '0);
  assign pop        = qv & qr;
  assign q          = qv ? mem_q[rp_q] : '0;
  assign snap_now   = (state_q == WAIT) && (dly_q == '0);

  assign pad_entry = {PAD,
                      (li_q == 2'd3) ? lane_q[2] : PAD,
                      (li_q >= 2'd2) ? lane_q[1] : PAD,
                      lane_q[0]};
  assign trl_entry = {TRL_TAG, 16'h0, frame_q, 16'h0, snap_corner_q, 16'h0, snap_drop_q};

  always_comb begin
    wr_data = pad_entry;
    if (wr_pend_q)                 wr_data = wr_data_q;
    else if (state_q == TRAILER)   wr_data = trl_entry;
  end

  // Saturating live counters; dv words count even when dropped.
  always_comb begin
    drop_inc   = (entry_drop ? 3'd4 : 3'd0) + (lost ? 3'd1 : 3'd0);
    corner_sum = {1'b0, corner_q} + 17'(dv);
    drop_sum   = {1'b0, drop_q} + 17'(drop_inc);
    corner_d   = corner_sum[16] ? 16'hFFFF : corner_sum[15:0];
    drop_d     = drop_sum[16]   ? 16'hFFFF : drop_sum[15:0];
  end

  always_ff @(posedge c) begin
    if (!rst_n) begin
      li_q      <= '0;
      lane_q    <= '0;
      wr_pend_q <= 1'b0;
      wr_data_q <= '0;
    end else begin
      wr_pend_q <= take && (li_q == 2'd3);
      if (take) begin
        if (li_q == 2'd3) wr_data_q <= {d, lane_q[2], lane_q[1], lane_q[0]};
        for (int k = 0; k < 3; k++)
          if (li_q == 2'(k)) lane_q[k] <= d;
        li_q <= li_q + 2'd1;
      end else if ((state_q == FLUSH) && fsm_wr) begin
        li_q <= '0;
      end
    end
  end

  always_ff @(posedge c) begin
    if (!rst_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (wr_en) wp_q <= wp_q + 1'b1;
      if (pop)   rp_q <= rp_q + 1'b1;
      case ({wr_en, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge c) begin
    if (wr_en) mem_q[wp_q] <= wr_data;
  end

  always_ff @(posedge c) begin
    if (!rst_n) begin
      fv_d1_q  <= 1'b0;
      ovf_q    <= 1'b0;
      corner_q <= '0;
      drop_q   <= '0;
    end else begin
      fv_d1_q <= fv;
      if (entry_drop || lost)  ovf_q <= 1'b1;
      else if (fv && !fv_d1_q) ovf_q <= 1'b0;
      if (snap_now) begin
        corner_q <= '0;
        drop_q   <= '0;
      end else begin
        corner_q <= corner_d;
        drop_q   <= drop_d;
      end
    end
  end

  always_ff @(posedge c) begin
    if (!rst_n) begin
      state_q       <= COLLECT;
      dly_q         <= '0;
      snap_corner_q <= '0;
      snap_drop_q   <= '0;
      frame_q       <= '0;
    end else begin
      case (state_q)
        COLLECT: if (fv_d1_q && !fv) begin
          state_q <= WAIT;
          dly_q   <= DW'(FLUSH_DELAY);
        end
        WAIT: if (dly_q == '0) begin
          state_q       <= FLUSH;
          snap_corner_q <= corner_d;
          snap_drop_q   <= drop_d;
        end else begin
          dly_q <= dly_q - 1'b1;
        end
        FLUSH: if ((li_q == 2'd0) || fsm_wr) state_q <= TRAILER;
        TRAILER: if (fsm_wr) begin
          frame_q <= frame_q + 16'd1;
          state_q <= COLLECT;
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

  assign overflow  = ovf_q;
  assign frame_cnt = frame_q;

endmodule

// File: tb/tb_corner_packer.sv
// Directed bench for corner_packer: packing, frame-end flush/trailer, overflow and reset.
module tb_corner_packer;
  localparam int DEPTH = 16;
  localparam int FD    = 32;

  logic         c = 1'b0, rst_n = 1'b0, dv = 1'b0, fv = 1'b0, qr = 1'b0;
  logic [31:0]  d = '0;
  logic [127:0] q;
  logic         qv, overflow;
  logic [15:0]  frame_cnt;

  int n_cmp = 0, n_err = 0;

  corner_packer #(.DEPTH(DEPTH), .FLUSH_DELAY(FD)) dut (
    .c(c), .rst_n(rst_n), .d(d), .dv(dv), .fv(fv),
    .q(q), .qv(qv), .qr(qr), .overflow(overflow), .frame_cnt(frame_cnt)
  );

  always #5 c = ~c;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge c);
    #1;
  endtask

  task automatic word(input logic [31:0] w);
    d = w; dv = 1'b1;
    step();
    dv = 1'b0;
  endtask

  function automatic logic [127:0] ent(input logic [31:0] b);
    return {b + 32'd3, b + 32'd2, b + 32'd1, b};
  endfunction

  function automatic logic [127:0] trl(input logic [15:0] f, input logic [15:0] cn, input logic [15:0] dr);
    return {32'hFFFF_E0F0, 16'h0, f, 16'h0, cn, 16'h0, dr};
  endfunction

  initial begin
    step(2);
    chk("rst_q",     q, '0);
    chk("rst_qv",    {127'b0, qv}, 128'd0);
    chk("rst_ovf",   {127'b0, overflow}, 128'd0);
    chk("rst_frame", {112'b0, frame_cnt}, 128'd0);

    // Packing: eight words back to back, consumer always ready
    rst_n = 1'b1; fv = 1'b1; qr = 1'b1;
    step();
    for (int i = 1; i <= 8; i++) begin
      word(32'(i));
      if (i == 4) chk("pack_lat_qv0", {127'b0, qv}, 128'd0);
      if (i == 5) begin
        chk("pack_lat_qv1", {127'b0, qv}, 128'd1);
        chk("pack_e0", q, 128'h00000004_00000003_00000002_00000001);
      end
    end
    step();
    chk("pack_e1", q, 128'h00000008_00000007_00000006_00000005);
    step();
    chk("pack_empty", {127'b0, qv}, 128'd0);

    rst_n = 1'b0; step(); rst_n = 1'b1;

    // Partial flush: five words then frame end
    for (int i = 0; i < 5; i++) word(32'h11 + 32'(i));
    fv = 1'b0;
    step();
    step(FD);
    step();
    chk("flush_timing_qv0", {127'b0, qv}, 128'd0);
    step();
    chk("flush_pad_qv", {127'b0, qv}, 128'd1);
    chk("flush_pad", q, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_00000015);
    step();
    chk("flush_trl", q, trl(16'd0, 16'd5, 16'd0));
    chk("flush_frame", {112'b0, frame_cnt}, 128'd1);
    step();
    chk("flush_drained", {127'b0, qv}, 128'd0);

    // Empty frame: trailer only
    fv = 1'b1; step();
    fv = 1'b0; step();
    step(FD + 1);
    step();
    chk("empty_nopad", {127'b0, qv}, 128'd0);
    step();
    chk("empty_trl", q, trl(16'd1, 16'd0, 16'd0));
    step();

    // Overflow: 68 words with no consumer
    qr = 1'b0; fv = 1'b1; step();
    for (int i = 0; i < 68; i++) word(32'h100 + 32'(i));
    step(2);
    chk("ovf_set",  {127'b0, overflow}, 128'd1);
    chk("ovf_head", q, ent(32'h100));
    fv = 1'b0; step();
    step(FD + 10);
    chk("ovf_stall_q",     q, ent(32'h100));
    chk("ovf_stall_frame", {112'b0, frame_cnt}, 128'd2);
    qr = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (k == 0 || k == 15) chk("ovf_drain", q, ent(32'h100 + 32'(4 * k)));
      step();
    end
    chk("ovf_trl", q, trl(16'd2, 16'd68, 16'd4));
    chk("ovf_frame", {112'b0, frame_cnt}, 128'd3);
    step();

    // dv while FLUSH is stalled on a full FIFO
    fv = 1'b1; step();
    chk("ovf_clear", {127'b0, overflow}, 128'd0);
    qr = 1'b0;
    for (int i = 0; i < 65; i++) word(32'h200 + 32'(i));
    fv = 1'b0; step();
    step(FD + 5);
    word(32'hDEAD_0001);
    chk("flushdrop_ovf", {127'b0, overflow}, 128'd1);
    qr = 1'b1;
    step(16);
    chk("flushdrop_pad", q, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_00000240);
    step();
    chk("flushdrop_trl", q, trl(16'd3, 16'd65, 16'd0));
    step();
    chk("flushdrop_empty", {127'b0, qv}, 128'd0);
    fv = 1'b1; step();
    chk("next_ovf_clear", {127'b0, overflow}, 128'd0);
    fv = 1'b0; step();
    step(FD + 3);
    chk("next_trl", q, trl(16'd4, 16'd1, 16'd1));
    step();

    // Reset mid-frame after three words
    fv = 1'b1; step();
    for (int i = 0; i < 3; i++) word(32'h21 + 32'(i));
    rst_n = 1'b0; step(); rst_n = 1'b1;
    chk("midrst_qv",    {127'b0, qv}, 128'd0);
    chk("midrst_frame", {112'b0, frame_cnt}, 128'd0);
    for (int i = 0; i < 4; i++) word(32'h31 + 32'(i));
    step();
    chk("midrst_entry", q, 128'h00000034_00000033_00000032_00000031);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
